// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encoding, status bit indices and default datapath width.
package alu_pkg;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_NOTB = 2'b11} alu_op_e;
  localparam int STATUS_Z = 0;
  localparam int STATUS_N = 1;
  localparam int STATUS_V = 2;
  localparam int ALU_WIDTH = 16;
endpackage

// File: rtl/alu_exec_stage_core.sv
// alu_core: combinational ALU result and Z/N/V flags; V is built only with ALU_STATUS_OVF_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             n,
  output logic             v
);
  assign r = op == ALU_ADD ? a + b :
             op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b : ~b;
  assign z = r == '0;
  assign n = r[WIDTH-1];
`ifdef ALU_STATUS_OVF_EN
  assign v = op == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]) :
             op == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]) : 1'b0;
`else
  assign v = 1'b0;
`endif
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: ALU execute stage with 2-entry in-order result queue and {V,N,Z} status.
// Define ALU_STATUS_OVF_EN to build overflow (V) detection; otherwise status[2] is 0.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] sout,
  input  logic [1:0]       alu_op,
  input  logic             loads,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic [2:0]       status
);
  logic [WIDTH-1:0] r;
  logic             z, n, v, acc, pop;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [2:0]       status_q, status_d;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a(ain), .b(sout), .op(alu_op_e'(alu_op)), .r(r), .z(z), .n(n), .v(v)
  );

  // in_ready comes only from the registered count, keeping out_ready off this path
  assign in_ready  = int'(cnt_q) < DEPTH;
  assign out_valid = cnt_q != 2'd0;
  assign c_out     = mem_q[rd_ptr_q];
  assign status    = status_q;
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    status_d = status_q;
    if (acc) mem_d[wr_ptr_q] = r;
    if (acc && loads) begin
      status_d[STATUS_V] = v;
      status_d[STATUS_N] = n;
      status_d[STATUS_Z] = z;
    end
    wr_ptr_d = wr_ptr_q ^ acc;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(acc) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      status_q <= 3'b000;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors with hand-computed results for alu_exec_stage.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, loads, out_valid, out_ready;
  logic [15:0] ain, sout, c_out;
  logic [1:0]  alu_op;
  logic [2:0]  status;
  int          n_vec = 0;
  int          n_err = 0;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ain(ain), .sout(sout), .alu_op(alu_op), .loads(loads),
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic ld);
    in_valid = v;
    alu_op   = op;
    ain      = a;
    sout     = b;
    loads    = ld;
  endtask

  localparam logic [15:0] AND_A [3] = '{16'hF0F0, 16'h1234, 16'hFFFF};
  localparam logic [15:0] AND_B [3] = '{16'hFF00, 16'h00FF, 16'h8001};
  localparam logic [15:0] AND_R [3] = '{16'hF000, 16'h0034, 16'h8001};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] ovf_status;
`ifdef ALU_STATUS_OVF_EN
    ovf_status = 3'b110;
`else
    ovf_status = 3'b010;
`endif
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0005, 16'h0006, 1'b1);
    repeat (3) tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    drive(1'b1, 2'b00, 16'h7FFF, 16'h0001, 1'b1);
    tick;
    chk("add_ovf_valid", 32'(out_valid), 32'd1);
    chk("add_ovf_c", 32'(c_out), 32'h8000);
    chk("add_ovf_status", 32'(status), 32'(ovf_status));
    drive(1'b1, 2'b01, 16'h1234, 16'h1234, 1'b1);
    tick;
    chk("sub_zero_c", 32'(c_out), 32'd0);
    chk("sub_zero_status", 32'(status), 32'b001);
    chk("sub_zero_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 2'b11, 16'hABCD, 16'h00FF, 1'b0);
    tick;
    chk("notb_c", 32'(c_out), 32'hFF00);
    chk("notb_status_hold", 32'(status), 32'b001);
    in_valid = 1'b0;
    tick;
    chk("drain_valid", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'd1, 16'd2, 1'b0);
    tick;
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    drive(1'b1, 2'b00, 16'd3, 16'd4, 1'b0);
    tick;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(c_out), 32'd3);
    drive(1'b1, 2'b00, 16'h0100, 16'h0001, 1'b0);
    tick;
    chk("bp_third_blocked", 32'(in_ready), 32'd0);
    chk("bp_head_hold", 32'(c_out), 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_pop1_c", 32'(c_out), 32'd7);
    chk("bp_pop1_valid", 32'(out_valid), 32'd1);
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    tick;
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_status_hold", 32'(status), 32'b001);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, AND_A[i], AND_B[i], 1'b0);
      tick;
      chk("stream_c", 32'(c_out), 32'(AND_R[i]));
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick;
    chk("stream_drain", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'd10, 16'd20, 1'b1);
    tick;
    drive(1'b1, 2'b11, 16'd0, 16'd0, 1'b1);
    tick;
    in_valid = 1'b0;
    chk("mid_full", 32'(in_ready), 32'd0);
    chk("mid_head", 32'(c_out), 32'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_c", 32'(c_out), 32'd0);
    chk("mid_rst_status", 32'(status), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("mid_after_valid", 32'(out_valid), 32'd0);
    chk("mid_after_ready", 32'(in_ready), 32'd1);
    tick;
    chk("mid_never_out", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage placed directly downstream of the shifter in the lab datapath. It accepts the A operand and the shifted B operand under a valid/ready handshake and computes one of four ALU operations. Results are buffered in a 2-entry output queue, which replaces the bare C register. A status register {V,N,Z} is updated when an operation is accepted.

## Interface
Parameters:
- `WIDTH`, 16, datapath width in bits; all arithmetic rules below assume the MSB is the sign bit.
- `DEPTH`, 2, output queue entries; only 2 is supported.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an operand pair and op are presented.
- `in_ready`  out  1  stage can accept this cycle.
- `ain`  in  WIDTH  A operand.
- `sout`  in  WIDTH  B operand, taken straight from the shifter output.
- `alu_op`  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 NOTB.
- `loads`  in  1  update the status register when this op is accepted.
- `out_valid`  out  1  `c_out` holds a result.
- `out_ready`  in  1  consumer takes the head result.
- `c_out`  out  WIDTH  head-of-queue result.
- `status`  out  3  {V,N,Z} flags.

## Operation
- Accept occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready` = (count < 2). It depends only on the registered count, so there is no combinational path from `out_ready`.
- Result `r` is computed as follows:
  - ADD: `ain + sout`, modulo 2^WIDTH.
  - SUB: `ain - sout`, two's complement.
  - AND: `ain & sout`.
  - NOTB: `~sout`, with `ain` ignored.
- Flags:
  - Z = (r == 0).
  - N = r[WIDTH-1].
  - V for ADD = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - V for SUB = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - V for AND and NOTB = 0.
- Status updates in the accept cycle when `loads`=1. It holds otherwise, including while the result waits in the queue.
- Queue is in-order, 2 entries, pointer-based with count 0..2. `c_out` and `out_valid` are driven from the head entry register.
- Simultaneous accept and pop:
  - count 1: count stays 1; the new result becomes head on the next cycle.
  - count 2: cannot occur, because `in_ready` is 0.
  - count 0: the new result becomes head; the pop is invalid, since `out_valid` is 0.
- `in_valid` with `in_ready`=0: no state change. The upstream stage holds its inputs.
- Pop with count 0: ignored.

## Timing
- Reset values (`rst_n` low): count 0, `out_valid` 0, `c_out` 0, `status` 3'b000, `in_ready` 1 once reset releases. Reset asserted mid-operation discards all queued results immediately and asynchronously.
- Latency: a result accepted at edge N appears on `c_out` with `out_valid`=1 after edge N when the queue was empty. When the queue was non-empty, it appears after the preceding entry pops.
- Throughput: 1 op per cycle with `out_ready` held high.
- Two accepts with `out_ready` low bring count to 2. `in_ready` drops the cycle after the second accept.
- A status change is visible the cycle after the accept edge.

## Configuration
- `ALU_STATUS_OVF_EN` defined: V is computed as specified above.
- Undefined: `status[2]` is tied to 0, no overflow logic is built, and Z and N are unchanged.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum (ADD, SUB, AND, NOTB).
  - `STATUS_Z`=0, `STATUS_N`=1, `STATUS_V`=2 index constants.
  - Default `WIDTH` localparam.
- Sub-module `alu_core`: purely combinational `r` and flag computation, from (a, b, op) to (r, z, n, v). The queue and status register stay in `alu_exec_stage`.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `c_out`=0, `status`=000. After release, `in_ready`=1.
- ADD overflow: `ain`=16'h7FFF, `sout`=16'h0001, op 00, `loads`=1 → `c_out`=16'h8000 the next cycle, `status`={V,N,Z}=110. With the macro undefined, expect 010.
- SUB zero: `ain`=16'h1234, `sout`=16'h1234, op 01, `loads`=1 → `c_out`=0, status 001. Repeat with `loads`=0 and op NOTB on `sout`=16'h00FF → `c_out`=16'hFF00, status unchanged at 001.
- Backpressure: `out_ready`=0, accept ADD 1+2 and ADD 3+4 → `in_ready`=0 after the second accept, and a third `in_valid` is not accepted. Raise `out_ready` → `c_out` shows 3, then 7, then `out_valid`=0.
- Streaming: `out_ready`=1, back-to-back AND ops on consecutive cycles → one result per cycle in order, with `in_ready` staying 1.
- Mid-operation reset: with count=2, pulse `rst_n` low asynchronously between edges → `out_valid` drops immediately and the queued results are never output.
